// File: rtl/pulse_stretcher.sv
// Stretches single-cycle request pulses into HIGH_CYCLES-high / GAP_CYCLES-low windows,
// queueing pulses that arrive mid-window in a saturating pending counter.
module pulse_stretcher #(
  parameter  int unsigned HIGH_CYCLES = 4,
  parameter  int unsigned GAP_CYCLES  = 2,
  parameter  int unsigned PEND_DEPTH  = 3,
  localparam int unsigned PW          = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  input  logic          ovf_clr,
  output logic          level_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow,
  output logic          done
);

  localparam int unsigned MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(PEND_DEPTH);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   pend_nxt;
  logic            ovf_nxt, done_nxt;
  logic            decide;

  // The end-of-window decision happens at the end of GAP, or at the end of HIGH when there is no gap.
  always_comb begin
    decide = ((state == HIGH) && (cnt == HIGH_LAST) && (GAP_CYCLES == 0)) ||
             ((state == GAP)  && (cnt == GAP_LAST));
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    pend_nxt  = pending;
    ovf_nxt   = overflow & ~ovf_clr;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pulse_in) state_nxt = HIGH;
      end
      HIGH: begin
        if (cnt == HIGH_LAST) begin
          cnt_nxt = '0;
          if (GAP_CYCLES != 0) state_nxt = GAP;
        end
      end
      GAP: ;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (decide) begin
      cnt_nxt = '0;
      if (pending != '0) begin
        state_nxt = HIGH;
        // A pulse on the dequeue edge replaces the dequeued entry.
        if (!pulse_in) pend_nxt = pending - PW'(1);
      end else if (pulse_in) begin
        state_nxt = HIGH;
      end else begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end else if ((state == HIGH || state == GAP) && pulse_in) begin
      if (pending < PEND_MAX) pend_nxt = pending + PW'(1);
      else                    ovf_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pending  <= pend_nxt;
      overflow <= ovf_nxt;
      done     <= done_nxt;
    end
  end

  assign level_out = (state == HIGH);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed and random bench for pulse_stretcher against a window-position reference model.
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int D  = 3;
  localparam int PW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pulse_in = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          level_out, busy, overflow, done;
  logic [PW-1:0] pending;

  int checks = 0;
  int errors = 0;

  // Reference model: is a window active, position within it, queue depth, flags.
  int m_act, m_pos, m_pend, m_ovf, m_done;

  pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .ovf_clr(ovf_clr),
    .level_out(level_out), .busy(busy), .pending(pending),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("level_out", 32'(level_out), 32'((m_act != 0) && (m_pos < H)));
    chk("busy",      32'(busy),      32'(m_act));
    chk("pending",   32'(pending),   32'(m_pend));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("done",      32'(done),      32'(m_done));
  endtask

  task automatic model_reset();
    m_act = 0; m_pos = 0; m_pend = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic model_edge(input int p, input int c);
    if (c != 0) m_ovf = 0;
    m_done = 0;
    if (m_act == 0) begin
      if (p != 0) begin m_act = 1; m_pos = 0; end
    end else if (m_pos == H + G - 1) begin
      if (m_pend > 0) begin
        m_pos = 0;
        if (p == 0) m_pend--;
      end else if (p != 0) begin
        m_pos = 0;
      end else begin
        m_act = 0; m_pos = 0; m_done = 1;
      end
    end else begin
      m_pos++;
      if (p != 0) begin
        if (m_pend < D) m_pend++;
        else m_ovf = 1;
      end
    end
  endtask

  task automatic step(input int p, input int c);
    pulse_in = (p != 0);
    ovf_clr  = (c != 0);
    @(posedge clk);
    model_edge(p, c);
    #1;
    chk_model();
  endtask

  // Asserts reset at a negedge, checks the asynchronous drop, releases at the next negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pulse_in = 1'b0;
    ovf_clr = 1'b0;
    #1;
    model_reset();
    chk_model();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset then 20 quiet cycles
    do_reset();
    for (int e = 1; e <= 20; e++) step(0, 0);

    // Single pulse
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      step(e == 1, 0);
      if (e == 7) chk("single_done", 32'(done), 32'd1);
    end

    // Three pulses queue two replays
    do_reset();
    for (int e = 1; e <= 22; e++) begin
      step(e <= 3, 0);
      if (e == 3)  chk("three_pend", 32'(pending), 32'd2);
      if (e == 19) chk("three_done", 32'(done), 32'd1);
    end

    // Saturation and overflow, cleared at edge 30
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      step(e <= 5, e == 30);
      if (e == 5) begin
        chk("sat_pend", 32'(pending), 32'd3);
        chk("sat_ovf",  32'(overflow), 32'd1);
      end
      if (e == 25) chk("sat_done", 32'(done), 32'd1);
      if (e == 30) chk("ovf_clr",  32'(overflow), 32'd0);
    end

    // Pulse on the decision edge restarts without a done strobe
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step(e == 1 || e == 7, 0);
      if (e == 7) begin
        chk("dec_level", 32'(level_out), 32'd1);
        chk("dec_done",  32'(done), 32'd0);
        chk("dec_pend",  32'(pending), 32'd0);
      end
    end

    // Reset mid-HIGH with two queued
    do_reset();
    for (int e = 1; e <= 3; e++) step(e <= 3, 0);
    chk("pre_rst_pend", 32'(pending), 32'd2);
    do_reset();
    for (int e = 1; e <= 15; e++) step(0, 0);

    // Random traffic with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(149) == 0) do_reset();
      else step($urandom_range(2) == 0, $urandom_range(15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
